div_seq: RTL and testbench

- Multi-cycle iterative divider sequencer for DIV/DIVU, driven by the EX stage's handshake signals: div_start, div_signed, div_op1, div_op2, div_ready, div_result.
- EX holds start plus operands and stalls the pipeline until ready. The block then returns {remainder, quotient} for the HI/LO write.
- Owns the divide FSM, iteration counter, sign fix-up, divide-by-zero path and annul (flush) abort.

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq_abs_fix.sv | 13 +
 rtl/div_seq.sv | 136 +++++++++++++
 tb/tb_div_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, handshake
// levels and the double-width result bus type.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef logic [2*DIV_DATA_W-1:0] double_reg_bus_t;

endpackage

// File: rtl/div_seq_abs_fix.sv
// Conditional two's-complement: used both to take operand magnitudes and to
// restore the sign of the quotient and remainder.
module div_seq_abs_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU. EX holds start and the operands
// until ready; the block returns {remainder, quotient} for the HI/LO write.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [2*DATA_W-1:0]     work;     // {partial remainder, dividend/quotient}
  logic [DATA_W-1:0]       divisor;
  logic                    q_neg;
  logic                    r_neg;

  logic [DATA_W-1:0] op1_abs, op2_abs, quo_fix, rem_fix;
  logic [DATA_W:0]   hi;
  logic [DATA_W-1:0] sub;
  logic              ge;
  logic [2*DATA_W-1:0] step_next;
  logic              abort;

  div_seq_abs_fix #(.W(DATA_W)) u_op1_abs (
    .value (opdata1_i),
    .negate(signed_div_i & opdata1_i[DATA_W-1]),
    .result(op1_abs)
  );

  div_seq_abs_fix #(.W(DATA_W)) u_op2_abs (
    .value (opdata2_i),
    .negate(signed_div_i & opdata2_i[DATA_W-1]),
    .result(op2_abs)
  );

  div_seq_abs_fix #(.W(DATA_W)) u_quo_fix (
    .value (work[DATA_W-1:0]),
    .negate(q_neg),
    .result(quo_fix)
  );

  div_seq_abs_fix #(.W(DATA_W)) u_rem_fix (
    .value (work[2*DATA_W-1:DATA_W]),
    .negate(r_neg),
    .result(rem_fix)
  );

  // One restoring step: hi is the upper half after the left shift, including
  // the bit shifted out. When hi >= divisor the difference fits in DATA_W bits.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    hi        = work[2*DATA_W-1:DATA_W-1];
    ge        = (hi >= {1'b0, divisor});
    sub       = hi[DATA_W-1:0] - divisor;
    step_next = ge ? {sub, work[DATA_W-2:0], 1'b1}
                   : {work[2*DATA_W-2:0], 1'b0};
  end

  // Annul wins over start; start dropping mid-divide is treated as an abort.
  assign abort = annul_i | (start_i == DIV_STOP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= '0;
              work    <= {{DATA_W{1'b0}}, op1_abs};
              divisor <= op2_abs;
              q_neg   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg   <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state <= DIV_END;
            work  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
          end
        end
        DIV_ON: begin
          if (abort) begin
            state <= DIV_FREE;
          end else begin
            work <= step_next;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state <= DIV_END;
          end
        end
        DIV_END: begin
          if (abort) begin
            state    <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end else begin
            ready_o  <= DIV_RESULT_READY;
            result_o <= {rem_fix, quo_fix};
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: unsigned/signed results, latency, divide by
// zero, annul, held END and asynchronous reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a divide with start held; check ready stays low through edge k+32
  // and rises with the expected result after edge k+33.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    tick();
    repeat (32) tick();
    check({tag, "_not_ready_k32"}, 64'(ready), 64'd0);
    tick();
    check({tag, "_ready_k33"}, 64'(ready), 64'd1);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_ready_cleared"}, 64'(ready), 64'd0);
    check({tag, "_result_cleared"}, result, 64'd0);
  endtask

  initial begin
    logic        saw_ready;
    logic [63:0] held;

    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    #2;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    #10 rst = 1'b1;
    tick();
    tick();
    check("idle_ready", 64'(ready), 64'd0);

    // Unsigned and signed arithmetic
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    drop_start("divu_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drop_start("div_m7_2");
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    drop_start("div_min_m1");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
    drop_start("div_7_m2");
    run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'hF, 32'h0FFF_FFFF});
    drop_start("divu_max_16");

    // Divide by zero: ready after edge k+2 with a zero result
    signed_div = 1'b1;
    op1        = 32'hFFFF_FF00;
    op2        = 32'd0;
    start      = 1'b1;
    tick();
    check("byzero_k0", 64'(ready), 64'd0);
    tick();
    check("byzero_k1", 64'(ready), 64'd0);
    tick();
    check("byzero_ready_k2", 64'(ready), 64'd1);
    check("byzero_result", result, 64'd0);
    drop_start("byzero");

    // Annul at ON iteration 10: ready never rises, then a fresh divide works
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul     = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      if (ready) saw_ready = 1'b1;
    end
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Hold start in END with changing operands: outputs stay put
    held = {32'd0, 32'd3};
    for (int i = 0; i < 5; i++) begin
      op1 = 32'h1234_0000 + 32'(i);
      op2 = 32'd0;
      tick();
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, held);
    end
    drop_start("hold");

    // Annul beats held start in END
    run_div("annul_end_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});
    annul = 1'b1;
    tick();
    check("annul_end_ready", 64'(ready), 64'd0);
    check("annul_end_result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();

    // Annul together with start in FREE blocks the launch
    op1   = 32'd8;
    op2   = 32'd0;
    start = 1'b1;
    annul = 1'b1;
    saw_ready = 1'b0;
    repeat (6) begin
      tick();
      if (ready) saw_ready = 1'b1;
    end
    check("annul_free_blocks", 64'(saw_ready), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    tick();

    // Asynchronous reset while ready is high clears outputs between edges
    run_div("rst_end_21_4", 1'b0, 32'd21, 32'd4, {32'd1, 32'd5});
    #2 rst = 1'b0;
    #1;
    check("rst_async_ready", 64'(ready), 64'd0);
    check("rst_async_result", result, 64'd0);
    start = 1'b0;
    #2 rst = 1'b1;

    // Asynchronous reset mid-ON, then idle stays FREE and a new divide works
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    tick();
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("rst_on_ready", 64'(ready), 64'd0);
    check("rst_on_result", result, 64'd0);
    start = 1'b0;
    #2 rst = 1'b1;
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      if (ready) saw_ready = 1'b1;
    end
    check("rst_on_idle", 64'(saw_ready), 64'd0);
    run_div("after_rst_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    drop_start("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
